// File: rtl/txn_fifo_bridge.sv
// txn_fifo_bridge: bounded transaction FIFO between a stimulus driver and the
// DUT-facing side. Valid/ready put port, first-word-fall-through get port with
// a registered head, occupancy, flush and sticky overflow status.
// Optional feature macro: TXN_FIFO_STATS_EN enables the 32-bit accepted
// put/get counters; without it put_cnt/get_cnt are tied to zero.
module txn_fifo_bridge #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     put_valid,
    input  logic [WIDTH-1:0]         put_data,
    output logic                     put_ready,
    output logic                     get_valid,
    output logic [WIDTH-1:0]         get_data,
    input  logic                     get_ready,
    output logic [$clog2(DEPTH):0]   used,
    output logic                     ovf_sticky,
    output logic [31:0]              put_cnt,
    output logic [31:0]              get_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("txn_fifo_bridge: DEPTH must be a power of 2 and >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    wr_cnt;
    logic [CW-1:0]    rd_cnt;
    logic             up;
    logic             full;
    logic             put_fire;
    logic             get_fire;
    logic [AW-1:0]    rd_ptr_next;
    logic             head_from_put;

    // Occupancy is the distance between the free-running write and read
    // counters; one extra bit distinguishes full from empty.
    assign used      = wr_cnt - rd_cnt;
    assign full      = (used == CW'(DEPTH));
    assign put_ready = up && !full && !flush;
    assign get_valid = (used != '0);

    // Flush discards any transfer presented in the same cycle.
    assign put_fire = put_valid && put_ready;
    assign get_fire = get_valid && get_ready && !flush;

    // The head after this edge is the freshly written slot only when that
    // slot is where the read pointer lands (single-entry / empty case).
    assign rd_ptr_next   = rd_cnt[AW-1:0] + AW'(get_fire);
    assign head_from_put = put_fire && (wr_cnt[AW-1:0] == rd_ptr_next);

    // Storage array: payload only, never reset.
    always_ff @(posedge clk) begin
        if (put_fire) begin
            mem[wr_cnt[AW-1:0]] <= put_data;
        end
    end

    // Control state: pointers, ready enable, overflow flag and registered head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up         <= 1'b0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            ovf_sticky <= 1'b0;
            get_data   <= '0;
        end else begin
            up <= 1'b1;
            if (flush) begin
                wr_cnt     <= '0;
                rd_cnt     <= '0;
                ovf_sticky <= 1'b0;
            end else begin
                wr_cnt   <= wr_cnt + CW'(put_fire);
                rd_cnt   <= rd_cnt + CW'(get_fire);
                get_data <= head_from_put ? put_data : mem[rd_ptr_next];
                if (put_valid && !put_ready) begin
                    ovf_sticky <= 1'b1;
                end
            end
        end
    end

`ifdef TXN_FIFO_STATS_EN
    logic [31:0] put_cnt_q;
    logic [31:0] get_cnt_q;

    // Accepted-transfer statistics, wrapping naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            put_cnt_q <= '0;
            get_cnt_q <= '0;
        end else if (flush) begin
            put_cnt_q <= '0;
            get_cnt_q <= '0;
        end else begin
            put_cnt_q <= put_cnt_q + 32'(put_fire);
            get_cnt_q <= get_cnt_q + 32'(get_fire);
        end
    end

    assign put_cnt = put_cnt_q;
    assign get_cnt = get_cnt_q;
`else
    assign put_cnt = '0;
    assign get_cnt = '0;
`endif

endmodule

// File: tb/tb_txn_fifo_bridge.sv
// Testbench for txn_fifo_bridge (WIDTH=32, DEPTH=8): directed vectors, a
// queue-based reference model compared every cycle, and literal checks.
module tb_txn_fifo_bridge;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              put_valid;
    logic [WIDTH-1:0]  put_data;
    logic              put_ready;
    logic              get_valid;
    logic [WIDTH-1:0]  get_data;
    logic              get_ready;
    logic [3:0]        used;
    logic              ovf_sticky;
    logic [31:0]       put_cnt;
    logic [31:0]       get_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    txn_fifo_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .put_valid  (put_valid),
        .put_data   (put_data),
        .put_ready  (put_ready),
        .get_valid  (get_valid),
        .get_data   (get_data),
        .get_ready  (get_ready),
        .used       (used),
        .ovf_sticky (ovf_sticky),
        .put_cnt    (put_cnt),
        .get_cnt    (get_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored transactions plus status.
    logic [WIDTH-1:0] mq[$];
    bit               m_up;
    bit               m_ovf;
    int unsigned      m_pc;
    int unsigned      m_gc;

    always @(posedge clk or negedge rst_n) begin
        bit pr;
        bit gv;
        if (!rst_n) begin
            mq.delete();
            m_up  = 1'b0;
            m_ovf = 1'b0;
            m_pc  = 0;
            m_gc  = 0;
        end else begin
            pr = m_up && (mq.size() < DEPTH) && !flush;
            gv = (mq.size() > 0);
            if (flush) begin
                mq.delete();
                m_ovf = 1'b0;
                m_pc  = 0;
                m_gc  = 0;
            end else begin
                if (put_valid && !pr) m_ovf = 1'b1;
                if (gv && get_ready) begin
                    void'(mq.pop_front());
                    m_gc++;
                end
                if (put_valid && pr) begin
                    mq.push_back(put_data);
                    m_pc++;
                end
            end
            m_up = 1'b1;
        end
    end

    // Per-cycle compare against the model, plus capture of delivered data.
    logic [WIDTH-1:0] got[$];
    int               max_used = 0;

    always @(negedge clk) begin
        chk("put_ready", put_ready, m_up && (mq.size() < DEPTH) && !flush);
        chk("get_valid", get_valid, mq.size() > 0);
        chk("used", used, mq.size());
        chk("ovf_sticky", ovf_sticky, m_ovf);
        if (mq.size() > 0) chk("get_data", get_data, mq[0]);
`ifdef TXN_FIFO_STATS_EN
        chk("put_cnt", put_cnt, m_pc);
        chk("get_cnt", get_cnt, m_gc);
`else
        chk("put_cnt", put_cnt, 0);
        chk("get_cnt", get_cnt, 0);
`endif
        if (rst_n && !flush && get_valid && get_ready) got.push_back(get_data);
        if (int'(used) > max_used) max_used = int'(used);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_put_ready"}, put_ready, 0);
        chk({tag, "_get_valid"}, get_valid, 0);
        chk({tag, "_get_data"}, get_data, 0);
        chk({tag, "_used"}, used, 0);
        chk({tag, "_ovf"}, ovf_sticky, 0);
        chk({tag, "_put_cnt"}, put_cnt, 0);
        chk({tag, "_get_cnt"}, get_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; put_valid = 1'b0; put_data = '0; get_ready = 1'b0;
        #2;
        chk_reset_values("reset");
        step(); step();
        rst_n = 1'b1;
        chk("ready_before_first_edge", put_ready, 0);
        step();
        chk("ready_after_release", put_ready, 1);

        // Fill to full with 1..8, no gets.
        for (int i = 1; i <= 8; i++) begin
            put_valid = 1'b1; put_data = i; step();
        end
        put_valid = 1'b0;
        chk("fill_used", used, 8);
        chk("fill_put_ready", put_ready, 0);
        chk("fill_head", get_data, 1);

        // Full: put and get together, only the get fires.
        put_valid = 1'b1; put_data = 32'h99; get_ready = 1'b1; step();
        put_valid = 1'b0; get_ready = 1'b0;
        chk("full_pg_used", used, 7);
        chk("full_pg_ovf", ovf_sticky, 1);
        get_ready = 1'b1;
        repeat (7) step();
        get_ready = 1'b0;
        chk("drain_used", used, 0);
        chk("drain_count", got.size(), 8);
        for (int i = 0; i < got.size(); i++) chk("drain_order", got[i], i + 1);

        // Flush clears the overflow flag.
        flush = 1'b1; step(); flush = 1'b0;
        chk("flush_ovf", ovf_sticky, 0);

        // Streaming 0..19.
        got.delete(); max_used = 0;
        chk("stream_idle_valid", get_valid, 0);
        for (int i = 0; i < 20; i++) begin
            put_valid = 1'b1; get_ready = 1'b1; put_data = i; step();
            if (i == 0) chk("stream_first_valid", get_valid, 1);
        end
        put_valid = 1'b0; step(); get_ready = 1'b0;
        chk("stream_count", got.size(), 20);
        for (int i = 0; i < got.size(); i++) chk("stream_order", got[i], i);
        chk("stream_used_le1", max_used <= 1, 1);

        // Flush with 5 entries stored and a put offered.
        got.delete();
        for (int i = 0; i < 5; i++) begin
            put_valid = 1'b1; put_data = 32'h50 + i; step();
        end
        put_valid = 1'b0;
        chk("pre_flush_used", used, 5);
        flush = 1'b1; put_valid = 1'b1; put_data = 32'hEE; step();
        flush = 1'b0; put_valid = 1'b0;
        chk("post_flush_used", used, 0);
        chk("post_flush_valid", get_valid, 0);
        chk("post_flush_ovf", ovf_sticky, 0);
        put_valid = 1'b1; put_data = 32'h77; step(); put_valid = 1'b0;
        get_ready = 1'b1; step(); step(); get_ready = 1'b0;
        chk("post_flush_count", got.size(), 1);
        if (got.size() > 0) chk("post_flush_data", got[0], 32'h77);

        // Async reset mid-stream with 3 entries and overflow set.
        got.delete();
        for (int i = 0; i < 8; i++) begin
            put_valid = 1'b1; put_data = 32'h30 + i; step();
        end
        step();
        put_valid = 1'b0;
        chk("pre_reset_ovf", ovf_sticky, 1);
        get_ready = 1'b1; repeat (5) step(); get_ready = 1'b0;
        chk("pre_reset_used", used, 3);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_reset_values("async_reset");
        step();
        rst_n = 1'b1;
        step();
        got.delete();
        put_valid = 1'b1; put_data = 32'hA5; step(); put_valid = 1'b0;
        get_ready = 1'b1; step(); step(); get_ready = 1'b0;
        chk("after_reset_count", got.size(), 1);
        if (got.size() > 0) chk("after_reset_first", got[0], 32'hA5);

        // Pointer wrap: three full fill/drain rounds.
        flush = 1'b1; step(); flush = 1'b0;
        got.delete();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                put_valid = 1'b1; put_data = 32'h100 + r * 8 + i; step();
            end
            put_valid = 1'b0;
            get_ready = 1'b1; repeat (8) step(); get_ready = 1'b0;
        end
        chk("wrap_count", got.size(), 24);
        for (int i = 0; i < got.size(); i++) chk("wrap_order", got[i], 32'h100 + i);
`ifdef TXN_FIFO_STATS_EN
        chk("wrap_put_cnt", put_cnt, 24);
        chk("wrap_get_cnt", get_cnt, 24);
`else
        chk("wrap_put_cnt", put_cnt, 0);
        chk("wrap_get_cnt", get_cnt, 0);
`endif

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
